// File: rtl/jtag_scan_master_if.sv
// Request/response handshake bundle between a scan client (master) and jtag_scan_master (slave).
// Requests and responses both use valid/ready; the bundle adds no storage of its own.
interface jtag_scan_master_if #(
  parameter int MAX_LEN = 32
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_ir_i;
  logic [LW-1:0]      req_len_i;
  logic [MAX_LEN-1:0] req_data_i;
  logic               reset_tap_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [MAX_LEN-1:0] rsp_data_o;

  modport master (
    output req_valid_i, req_ir_i, req_len_i, req_data_i, reset_tap_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_ir_i, req_len_i, req_data_i, reset_tap_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/jtag_scan_master.sv
// On-chip JTAG initiator: runs Test-Logic-Reset, then IR/DR scans per request, returning captured TDO.
// Latency len+5 (DR) / len+6 (IR) TCK steps of 2*CLK_DIV cycles; one scan in flight, ready low until the response is taken.
module jtag_scan_master #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  jtag_scan_master_if.slave host,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] ONE      = LW'(1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [2:0] {TLR_SEQ, IDLE, PRE, SHIFT, POST, RSP} state_t;

  state_t             state_q;
  logic [DW-1:0]      div_cnt_q;
  logic [2:0]         step_q;
  logic [LW-1:0]      bit_cnt_q;
  logic [LW-1:0]      last_q;
  logic               ir_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] rsp_data_q;
  logic               tck_q, tms_q, tdi_q;
  logic               req_ready_q, rsp_valid_q;
  logic [LW-1:0]      len_c;

  assign len_c = (host.req_len_i > LEN_MAX) ? LEN_MAX : host.req_len_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= TLR_SEQ;
      div_cnt_q   <= '0;
      step_q      <= '0;
      bit_cnt_q   <= '0;
      last_q      <= '0;
      ir_q        <= 1'b0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.reset_tap_i) begin
            state_q     <= TLR_SEQ;
            step_q      <= '0;
            tms_q       <= 1'b1;
            req_ready_q <= 1'b0;
          end else if (host.req_valid_i) begin
            req_ready_q <= 1'b0;
            ir_q        <= host.req_ir_i;
            data_q      <= host.req_data_i;
            last_q      <= len_c - ONE;
            rsp_data_q  <= '0;
            if (len_c == '0) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= PRE;
              step_q  <= '0;
              tms_q   <= 1'b1;
            end
          end
        end
        RSP: begin
          if (host.rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        // TLR_SEQ/PRE/SHIFT/POST share the TCK generator; a step ends when its high phase does
        default: begin
          if (div_cnt_q != DIV_LAST) begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end else begin
            div_cnt_q <= '0;
            tck_q     <= ~tck_q;
            if (!tck_q) begin
              if (state_q == SHIFT) rsp_data_q[bit_cnt_q[IW-1:0]] <= tdo_i;
            end else begin
              case (state_q)
                TLR_SEQ: begin
                  if (step_q == 3'd5) begin
                    state_q     <= IDLE;
                    tms_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                  end else begin
                    step_q <= step_q + 3'd1;
                    tms_q  <= (step_q != 3'd4);
                  end
                end
                PRE: begin
                  if (step_q == (ir_q ? 3'd3 : 3'd2)) begin
                    state_q   <= SHIFT;
                    bit_cnt_q <= '0;
                    tms_q     <= (last_q == '0);
                    tdi_q     <= data_q[0];
                  end else begin
                    step_q <= step_q + 3'd1;
                    tms_q  <= ir_q && (step_q == 3'd0);
                  end
                end
                SHIFT: begin
                  if (bit_cnt_q == last_q) begin
                    state_q <= POST;
                    step_q  <= '0;
                    tms_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                  end else begin
                    bit_cnt_q <= bit_cnt_q + ONE;
                    tms_q     <= (bit_cnt_q + ONE == last_q);
                    tdi_q     <= data_q[1];
                    data_q    <= data_q >> 1;
                  end
                end
                POST: begin
                  tms_q <= 1'b0;
                  if (step_q == 3'd1) begin
                    state_q     <= RSP;
                    rsp_valid_q <= 1'b1;
                  end else begin
                    step_q <= 3'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign tck_o            = tck_q;
  assign tms_o            = tms_q;
  assign tdi_o            = tdi_q;
  assign host.req_ready_o = req_ready_q;
  assign host.rsp_valid_o = rsp_valid_q;
  assign host.rsp_data_o  = rsp_data_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP with an 8-bit DR chain and 5-bit IR, plus a response scoreboard.
module tb_jtag_scan_master;
  localparam int MAX_LEN = 32;
  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi;
  logic tdo = 1'b0;

  jtag_scan_master_if #(.MAX_LEN(MAX_LEN)) bus ();

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .host  (bus.slave),
    .tck_o (tck),
    .tms_o (tms),
    .tdi_o (tdi),
    .tdo_i (tdo)
  );

  always #5 clk = ~clk;

  // Behavioural TAP
  typedef enum logic [3:0] {T_TLR, T_RTI, T_SDS, T_CDR, T_SDR, T_E1D, T_PDR, T_E2D, T_UDR,
                            T_SIS, T_CIR, T_SIR, T_E1I, T_PIR, T_E2I, T_UIR} tap_t;
  tap_t       tap_st = T_TLR;
  logic [7:0] dr_sr = '0, dr_upd = '0, dr_cap;
  logic [4:0] ir_sr = '0, ir_reg = '0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR: return m ? T_TLR : T_RTI;
      T_RTI: return m ? T_SDS : T_RTI;
      T_SDS: return m ? T_SIS : T_CDR;
      T_CDR: return m ? T_E1D : T_SDR;
      T_SDR: return m ? T_E1D : T_SDR;
      T_E1D: return m ? T_UDR : T_PDR;
      T_PDR: return m ? T_E2D : T_PDR;
      T_E2D: return m ? T_UDR : T_SDR;
      T_UDR: return m ? T_SDS : T_RTI;
      T_SIS: return m ? T_TLR : T_CIR;
      T_CIR: return m ? T_E1I : T_SIR;
      T_SIR: return m ? T_E1I : T_SIR;
      T_E1I: return m ? T_UIR : T_PIR;
      T_PIR: return m ? T_E2I : T_PIR;
      T_E2I: return m ? T_UIR : T_SIR;
      default: return m ? T_SDS : T_RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      T_CDR: dr_sr <= dr_cap;
      T_SDR: dr_sr <= {tdi, dr_sr[7:1]};
      T_UDR: dr_upd <= dr_sr;
      T_CIR: ir_sr <= 5'h01;
      T_SIR: ir_sr <= {tdi, ir_sr[4:1]};
      T_UIR: ir_reg <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo <= (tap_st == T_SDR) ? dr_sr[0] : (tap_st == T_SIR) ? ir_sr[0] : 1'b0;

  int tck_cnt = 0;
  bit tms_hist [0:1023];
  always @(posedge tck) begin
    tms_hist[tck_cnt % 1024] <= tms;
    tck_cnt <= tck_cnt + 1;
  end

  // Scoreboard
  typedef struct { logic [31:0] data; int tcks; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void scan_model(input bit ir, input int len, input logic [31:0] data,
                                     input logic [7:0] cap, output logic [31:0] rsp,
                                     output logic [7:0] upd);
    int w, eff;
    logic [7:0] sr;
    w = ir ? 5 : 8;
    eff = (len > 32) ? 32 : len;
    sr = cap;
    rsp = '0;
    for (int i = 0; i < eff; i++) begin
      rsp[i] = sr[0];
      sr = sr >> 1;
      sr[w-1] = data[i];
    end
    upd = sr;
  endfunction

  function automatic bit exp_tms(input bit ir, input int len, input int k);
    int pre;
    pre = ir ? 4 : 3;
    if (k < pre) return (k == 0) || (ir && k == 1);
    if (k < pre + len) return k == pre + len - 1;
    return k == pre + len;
  endfunction

  function automatic int tms_errs(input int start, input bit tlr, input int len, input bit ir);
    int n, e, eff;
    n = 0; e = 0;
    eff = (len > 32) ? 32 : len;
    if (tlr)
      for (int k = 0; k < 6; k++) begin
        if (tms_hist[(start + n) % 1024] != (k < 5)) e++;
        n++;
      end
    if (eff > 0)
      for (int k = 0; k < eff + (ir ? 6 : 5); k++) begin
        if (tms_hist[(start + n) % 1024] != exp_tms(ir, eff, k)) e++;
        n++;
      end
    return e;
  endfunction

  function automatic exp_t mk_exp(input bit ir, input int len, input logic [31:0] data);
    exp_t e;
    logic [7:0] upd;
    int eff;
    eff = (len > 32) ? 32 : len;
    scan_model(ir, len, data, ir ? 8'h01 : dr_cap, e.data, upd);
    e.tcks = (eff == 0) ? 0 : eff + (ir ? 6 : 5);
    return e;
  endfunction

  // Stimulus helpers (no checking)
  task automatic send_req(input bit ir, input logic [5:0] len, input logic [31:0] data, output bit ok);
    bus.req_ir_i = ir; bus.req_len_i = len; bus.req_data_i = data; bus.req_valid_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus.req_ready_o === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int n = 0; n < 2000; n++) begin
      if (bus.rsp_valid_o === 1'b1) begin ok = 1'b1; d = bus.rsp_data_o; break; end
      @(negedge clk);
    end
    if (bus.rsp_ready_i) @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus.req_ready_o === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int start; bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({tck, tms, tdi} !== 3'b010) begin errors++; $display("FAIL reset_pins got %b exp 010", {tck, tms, tdi}); end
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.rsp_data_o !== '0) begin errors++; $display("FAIL reset_rsp got %b/%h exp 0/0", bus.rsp_valid_o, bus.rsp_data_o); end
    start = tck_cnt;
    rst_n = 1'b1;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tlr_ready got timeout exp ready"); end
    checks++; if (tck_cnt - start != 6) begin errors++; $display("FAIL tlr_tcks got %0d exp 6", tck_cnt - start); end
    checks++; if (tms_errs(start, 1'b1, 0, 1'b0) != 0) begin errors++; $display("FAIL tlr_tms got %0d bad steps exp 0", tms_errs(start, 1'b1, 0, 1'b0)); end
    checks++; if (tap_st != T_RTI) begin errors++; $display("FAIL tlr_tap got %0d exp %0d", tap_st, T_RTI); end
  endtask

  task automatic test_scan(input bit ir, input int len, input logic [31:0] data, input logic [7:0] exp_reg);
    int start; bit ok; logic [31:0] d; exp_t e;
    exp_q.push_back(mk_exp(ir, len, data));
    start = tck_cnt;
    send_req(ir, 6'(len), data, ok);
    get_rsp(d, ok);
    e = exp_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL scan_rsp ir=%0d got timeout exp valid", ir); end
    checks++; if (d !== e.data) begin errors++; $display("FAIL scan_data ir=%0d len=%0d got %h exp %h", ir, len, d, e.data); end
    checks++; if (tck_cnt - start != e.tcks) begin errors++; $display("FAIL scan_tcks ir=%0d len=%0d got %0d exp %0d", ir, len, tck_cnt - start, e.tcks); end
    checks++; if (tms_errs(start, 1'b0, len, ir) != 0) begin errors++; $display("FAIL scan_tms ir=%0d got %0d bad steps exp 0", ir, tms_errs(start, 1'b0, len, ir)); end
    checks++; if ((ir ? {3'b0, ir_reg} : dr_upd) !== exp_reg) begin errors++; $display("FAIL scan_tapreg ir=%0d got %h exp %h", ir, ir ? {3'b0, ir_reg} : dr_upd, exp_reg); end
    checks++; if (tap_st != T_RTI) begin errors++; $display("FAIL scan_tapstate got %0d exp %0d", tap_st, T_RTI); end
  endtask

  task automatic test_reset_tap_priority;
    int start; bit ok; logic [31:0] d; exp_t e;
    dr_cap = 8'hC3;
    exp_q.push_back(mk_exp(1'b0, 8, 32'h5A));
    start = tck_cnt;
    bus.req_ir_i = 1'b0; bus.req_len_i = 6'd8; bus.req_data_i = 32'h5A;
    bus.req_valid_i = 1'b1; bus.reset_tap_i = 1'b1;
    @(negedge clk);
    bus.reset_tap_i = 1'b0;
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL prio_ready got %b exp 0", bus.req_ready_o); end
    wait_ready(ok);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    get_rsp(d, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL prio_data got %h exp %h", d, e.data); end
    checks++; if (tck_cnt - start != 6 + e.tcks) begin errors++; $display("FAIL prio_tcks got %0d exp %0d", tck_cnt - start, 6 + e.tcks); end
    checks++; if (tms_errs(start, 1'b1, 8, 1'b0) != 0) begin errors++; $display("FAIL prio_tms got %0d bad steps exp 0", tms_errs(start, 1'b1, 8, 1'b0)); end
    checks++; if (dr_upd !== 8'h5A) begin errors++; $display("FAIL prio_dr got %h exp 5a", dr_upd); end
  endtask

  task automatic test_len_zero;
    int start; bit ok; logic [31:0] d; exp_t e;
    exp_q.push_back(mk_exp(1'b0, 0, 32'hFFFF_FFFF));
    start = tck_cnt;
    send_req(1'b0, 6'd0, 32'hFFFF_FFFF, ok);
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL len0_valid got %b exp 1", bus.rsp_valid_o); end
    get_rsp(d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e.data) begin errors++; $display("FAIL len0_data got %h exp %h", d, e.data); end
    checks++; if (tck_cnt != start) begin errors++; $display("FAIL len0_tcks got %0d exp 0", tck_cnt - start); end
  endtask

  task automatic test_reset_mid_shift;
    int start; bit ok, saw;
    dr_cap = 8'hFF;
    send_req(1'b0, 6'd32, 32'h1234_5678, ok);
    for (int n = 0; n < 400 && tap_st != T_SDR; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({tck, tms, tdi} !== 3'b010) begin errors++; $display("FAIL midrst_pins got %b exp 010", {tck, tms, tdi}); end
    checks++; if (bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_hs got %b%b exp 00", bus.req_ready_o, bus.rsp_valid_o); end
    @(negedge clk);
    start = tck_cnt;
    rst_n = 1'b1;
    ok = 1'b0; saw = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus.rsp_valid_o === 1'b1) saw = 1'b1;
      if (bus.req_ready_o === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok || saw) begin errors++; $display("FAIL midrst_tlr got ready=%b rsp_seen=%b exp 1/0", ok, saw); end
    checks++; if (tck_cnt - start != 6) begin errors++; $display("FAIL midrst_tcks got %0d exp 6", tck_cnt - start); end
    checks++; if (tms_errs(start, 1'b1, 0, 1'b0) != 0 || tap_st != T_RTI) begin errors++; $display("FAIL midrst_tms got %0d bad steps tap=%0d exp 0/%0d", tms_errs(start, 1'b1, 0, 1'b0), tap_st, T_RTI); end
  endtask

  task automatic test_rsp_hold;
    bit ok; logic [31:0] d; exp_t e;
    dr_cap = 8'h3C;
    bus.rsp_ready_i = 1'b0;
    exp_q.push_back(mk_exp(1'b0, 4, 32'h9));
    send_req(1'b0, 6'd4, 32'h9, ok);
    get_rsp(d, ok);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== d || bus.req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d got v=%b d=%h r=%b exp v=1 d=%h r=0", n, bus.rsp_valid_o, bus.rsp_data_o, bus.req_ready_o, d);
      end
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", bus.rsp_valid_o); end
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL hold_data got %h exp %h", d, e.data); end
  endtask

  task automatic test_back_to_back;
    bit ok; logic [31:0] d1, d2; exp_t e;
    dr_cap = 8'h81;
    exp_q.push_back(mk_exp(1'b0, 8, 32'h0F));
    exp_q.push_back(mk_exp(1'b1, 5, 32'h02));
    send_req(1'b0, 6'd8, 32'h0F, ok);
    get_rsp(d1, ok);
    send_req(1'b1, 6'd5, 32'h02, ok);
    get_rsp(d2, ok);
    e = exp_q.pop_front();
    checks++; if (d1 !== e.data) begin errors++; $display("FAIL b2b_first got %h exp %h", d1, e.data); end
    e = exp_q.pop_front();
    checks++; if (d2 !== e.data) begin errors++; $display("FAIL b2b_second got %h exp %h", d2, e.data); end
    checks++; if (ir_reg !== 5'h02) begin errors++; $display("FAIL b2b_ir got %h exp 02", ir_reg); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_ir_i = 1'b0; bus.req_len_i = '0; bus.req_data_i = '0;
    bus.reset_tap_i = 1'b0; bus.rsp_ready_i = 1'b1;
    dr_cap = 8'h3C;
    @(negedge clk);
    test_reset;
    dr_cap = 8'h3C;
    test_scan(1'b0, 8, 32'hA5, 8'hA5);
    test_scan(1'b1, 5, 32'h1F, 8'h1F);
    test_reset_tap_priority;
    test_len_zero;
    dr_cap = 8'h96;
    test_scan(1'b0, 40, 32'hDEAD_BEEF, 8'hDE);
    test_reset_mid_shift;
    test_rsp_hold;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
